// File: rtl/addsub_sweep_checker_pkg.sv
// addsub_sweep_checker_pkg: shared types and sizes for the add/sub sweep checker
package addsub_sweep_checker_pkg;
    localparam int VEC_COUNT = 512;
    localparam int IDX_W     = 9;
    localparam int ERR_W     = 10;
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
endpackage

// File: rtl/addsub_sweep_checker_golden.sv
// addsub_golden: reference 4-bit two's complement add/sub with signed overflow
//   m : 0 = add, 1 = subtract
//   a, b : operands
//   s : result mod 16
//   v : signed overflow
module addsub_golden (
    input  logic       m,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       v
);
    logic [4:0] r;
    // Sign-extended 5-bit result; overflow when its top two bits disagree.
    assign r = m ? {a[3], a} - {b[3], b} : {a[3], a} + {b[3], b};
    assign s = r[3:0];
    assign v = r[4] ^ r[3];
endmodule

// File: rtl/addsub_sweep_checker.sv
// addsub_sweep_checker: drives all 512 {m,a,b} vectors into an add/sub DUT and checks its responses
//   clk, rst_n         : clock, async active-low reset
//   start              : begin a sweep (accepted in IDLE or DONE)
//   m_o, a_o, b_o      : vector driven to the DUT
//   s_i, v_i           : DUT result and overflow flag
//   busy, done, pass   : sweep status
//   err_count          : mismatching vectors in current/last sweep
//   fail_idx/s/v       : first mismatching vector and DUT response there
module addsub_sweep_checker
    import addsub_sweep_checker_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             m_o,
    output logic [3:0]       a_o,
    output logic [3:0]       b_o,
    input  logic [3:0]       s_i,
    input  logic             v_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] fail_idx,
    output logic [3:0]       fail_s,
    output logic             fail_v
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_COUNT - 1);
    state_t           state, nxt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       cnt;
    logic [3:0]       gs;
    logic             gv, acc, mis;

    addsub_golden u_golden (.m(m_o), .a(a_o), .b(b_o), .s(gs), .v(gv));

    // The vector index is the operand bundle itself.
    assign {m_o, a_o, b_o} = idx;
    assign mis = (s_i != gs) || (v_i != gv);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start ? DRIVE : state;
            DRIVE:      nxt = WAIT;
            WAIT:       nxt = cnt == 4'(SETTLE - 1) ? CHECK : WAIT;
            CHECK:      nxt = idx == LAST ? DONE : DRIVE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state inside {DRIVE, WAIT, CHECK};
        done = state == DONE;
        pass = done && err_count == '0;
        acc  = start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            fail_s    <= '0;
            fail_v    <= 1'b0;
        end else begin
            cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
            if (acc) begin
                idx       <= '0;
                err_count <= '0;
                fail_idx  <= '0;
                fail_s    <= '0;
                fail_v    <= 1'b0;
            end else if (state == CHECK) begin
                if (idx != LAST) idx <= idx + IDX_W'(1);
                if (mis) begin
                    err_count <= err_count + ERR_W'(1);
                    // Only the first mismatch of a sweep is captured.
                    if (err_count == '0) begin
                        fail_idx <= idx;
                        fail_s   <= s_i;
                        fail_v   <= v_i;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_sweep_checker.sv
// tb_addsub_sweep_checker: directed self-checking bench for addsub_sweep_checker
module tb_addsub_sweep_checker;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start3 = 1'b0;
    logic       m_o, v_i, busy, done, pass, fail_v;
    logic [3:0] a_o, b_o, s_i, fail_s;
    logic [9:0] err_count;
    logic [8:0] fail_idx;
    logic       m3, v3, busy3, done3, pass3, fail_v3;
    logic [3:0] a3, b3, s3, fail_s3;
    logic [9:0] err3;
    logic [8:0] fail_idx3;
    int         fault = 0;
    int         n_chk = 0, n_fail = 0;
    int         cyc;

    always #5 clk = ~clk;

    // Behavioural DUT: mode 0 correct, 1 overflow stuck at 0, 2 ignores m (always adds).
    function automatic logic [4:0] model(int mode, logic m, logic [3:0] a, logic [3:0] b);
        int ai, bi, r;
        ai = int'($signed(a));
        bi = int'($signed(b));
        r  = (m && mode != 2) ? ai - bi : ai + bi;
        return {mode != 1 && (r > 7 || r < -8), 4'(r)};
    endfunction

    function automatic int exp_errs(int mode);
        int n;
        logic [8:0] x;
        n = 0;
        for (int i = 0; i < 512; i++) begin
            x = 9'(i);
            if (model(mode, x[8], x[7:4], x[3:0]) != model(0, x[8], x[7:4], x[3:0])) n++;
        end
        return n;
    endfunction

    assign {v_i, s_i} = model(fault, m_o, a_o, b_o);
    assign {v3, s3}   = model(0, m3, a3, b3);

    addsub_sweep_checker #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m_o(m_o), .a_o(a_o), .b_o(b_o),
        .s_i(s_i), .v_i(v_i), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx), .fail_s(fail_s), .fail_v(fail_v)
    );

    addsub_sweep_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .m_o(m3), .a_o(a3), .b_o(b3),
        .s_i(s3), .v_i(v3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_idx(fail_idx3), .fail_s(fail_s3), .fail_v(fail_v3)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic zero_check(string tag);
        chk({tag, "_flags"}, {27'd0, busy, done, pass, fail_v, m_o}, 32'd0);
        chk({tag, "_ops"}, {24'd0, a_o, b_o}, 32'd0);
        chk({tag, "_err"}, {22'd0, err_count}, 32'd0);
        chk({tag, "_fidx"}, {23'd0, fail_idx}, 32'd0);
        chk({tag, "_fs"}, {28'd0, fail_s}, 32'd0);
    endtask

    // Called just after a rising edge; returns cycles from start acceptance to done.
    task automatic sweep(input int start_at, input int reset_at, output int n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("clear_on_start", {21'd0, busy, done, err_count}, {21'd0, 1'b1, 1'b0, 10'd0});
            if (start_at > 0 && n == 99) chk("idx33", {23'd0, m_o, a_o, b_o}, 32'd33);
            start = (n == start_at);
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1;
                zero_check("rst_mid");
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zero_check("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fault = 0;
        sweep(100, 0, cyc);
        chk("cyc_clean", cyc, 1536);
        chk("pass_clean", {29'd0, busy, done, pass}, {29'd0, 3'b011});
        chk("err_clean", {22'd0, err_count}, 32'd0);
        chk("last_vec", {23'd0, m_o, a_o, b_o}, 32'd511);

        fault = 1;
        sweep(0, 0, cyc);
        chk("cyc_vstuck", cyc, 1536);
        chk("err_vstuck", {22'd0, err_count}, exp_errs(1));
        chk("fidx_vstuck", {23'd0, fail_idx}, 32'd23);
        chk("fs_vstuck", {28'd0, fail_s}, 32'd8);
        chk("fv_vstuck", {31'd0, fail_v}, 32'd0);
        chk("pass_vstuck", {30'd0, done, pass}, {30'd0, 2'b10});

        fault = 2;
        sweep(0, 0, cyc);
        chk("err_nom", {22'd0, err_count}, exp_errs(2));
        chk("fidx_nom", {23'd0, fail_idx}, 32'd257);
        chk("fs_nom", {28'd0, fail_s}, 32'd1);
        chk("fv_nom", {31'd0, fail_v}, 32'd0);
        chk("pass_nom", {30'd0, done, pass}, {30'd0, 2'b10});

        fault = 0;
        sweep(0, 700, cyc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        zero_check("post_rst");
        sweep(0, 0, cyc);
        chk("cyc_after_rst", cyc, 1536);
        chk("pass_after_rst", {30'd0, done, pass}, {30'd0, 2'b11});

        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("cyc_settle3", cyc, 2560);
        chk("pass_settle3", {30'd0, done3, pass3}, {30'd0, 2'b11});

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
